note_key_encoder: RTL and testbench

- Front-end stage of the electronic piano: converts nine raw piano key switches into the 4-bit note code consumed by the colour decoder and the tone stage.
- Synchronises the keys, priority-encodes them and debounces the encoded code.
- Drives a stable code plus status strobes; code 0 means silence.
- Output bit note[0] feeds the decoder's p0 input, note[3] feeds p3.

---
 rtl/note_key_encoder_if.sv | 25 ++
 rtl/note_key_encoder.sv | 138 +++++++++++++
 tb/tb_note_key_encoder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_key_encoder_if.sv
// Key/note bundle between the piano key matrix and the encoder.
// The state field carries the encoder FSM state for observation.
interface note_key_encoder_if;
  logic [8:0] key;
  logic [3:0] note;
  logic       note_on;
  logic       note_chg;
  logic [1:0] state;

  modport master (
    output key,
    input  note,
    input  note_on,
    input  note_chg,
    input  state
  );

  modport slave (
    input  key,
    output note,
    output note_on,
    output note_chg,
    output state
  );
endinterface

// File: rtl/note_key_encoder.sv
// Piano key front end: synchronise, priority-encode and debounce nine keys into a note code.
// Optional macro SUSTAIN_EN holds the last note for SUSTAIN_CYCLES after full release.
module note_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SUSTAIN_CYCLES  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  note_key_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HELD = 2'd2,
    SUST = 2'd3
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  // Out-of-range parameters elaborate this empty marker block.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      SUSTAIN_CYCLES < 1 || SUSTAIN_CYCLES > 65535) begin : g_param_out_of_range
  end

  logic [8:0] s1, s2;
  logic [3:0] enc;
  logic [3:0] cand;
  logic [7:0] cnt;
  logic       stable;
  logic       commit;

  state_t     state, state_nx;
  logic [3:0] note, note_nx;
  logic       note_on;
  logic       note_chg, chg_nx;

`ifdef SUSTAIN_EN
  localparam logic [15:0] SUS_LOAD = 16'(SUSTAIN_CYCLES);
  logic [15:0] sus_cnt, sus_nx;
`endif

  // Iterating from the top down leaves the lowest pressed index in enc.
  always_comb begin
    enc = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (s2[i]) enc = 4'(i + 1);
    end
  end

  assign stable = (enc == cand) && (cnt == CNT_MAX);
  assign commit = stable && (cand != note);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 9'd0;
      s2   <= 9'd0;
      cand <= 4'd0;
      cnt  <= 8'd0;
    end else begin
      s1 <= bus.key;
      s2 <= s1;
      if (enc != cand) begin
        cand <= enc;
        cnt  <= 8'd0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    note_nx  = note;
    chg_nx   = 1'b0;
`ifdef SUSTAIN_EN
    sus_nx   = sus_cnt;
    if (state == SUST) begin
      if (commit && (cand != 4'd0)) begin
        note_nx  = cand;
        chg_nx   = 1'b1;
        state_nx = HELD;
        sus_nx   = 16'd0;
      end else if (stable && (cand == note)) begin
        // The sustained key came back: resume holding without a pulse.
        state_nx = HELD;
        sus_nx   = 16'd0;
      end else if (sus_cnt <= 16'd1) begin
        note_nx  = 4'd0;
        chg_nx   = 1'b1;
        state_nx = IDLE;
        sus_nx   = 16'd0;
      end else begin
        sus_nx = sus_cnt - 16'd1;
      end
    end else if (commit && (cand == 4'd0)) begin
      state_nx = SUST;
      sus_nx   = SUS_LOAD;
    end else
`endif
    if (commit) begin
      note_nx  = cand;
      chg_nx   = 1'b1;
      state_nx = (cand != 4'd0) ? HELD : IDLE;
    end else if (cand != note) begin
      state_nx = PEND;
    end else begin
      state_nx = (note != 4'd0) ? HELD : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      note     <= 4'd0;
      note_on  <= 1'b0;
      note_chg <= 1'b0;
    end else begin
      state    <= state_nx;
      note     <= note_nx;
      note_on  <= (note_nx != 4'd0);
      note_chg <= chg_nx;
    end
  end

`ifdef SUSTAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sus_cnt <= 16'd0;
    else        sus_cnt <= sus_nx;
  end
`endif

  assign bus.note     = note;
  assign bus.note_on  = note_on;
  assign bus.note_chg = note_chg;
  assign bus.state    = state;

endmodule

// File: tb/tb_note_key_encoder.sv
// Directed bench for note_key_encoder with default parameters (debounce 4, sustain 16).
// Inputs change just after a rising edge; outputs are sampled 1ns after each edge.
module tb_note_key_encoder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  note_key_encoder_if bus ();

  note_key_encoder #(
    .DEBOUNCE_CYCLES(4),
    .SUSTAIN_CYCLES (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release all keys and wait, bounded, until the encoder is idle again.
  task automatic go_idle();
    int n;
    bus.key = 9'd0;
    n = 0;
    while ((bus.note !== 4'd0 || bus.state !== 2'd0) && n < 60) begin
      step();
      n++;
    end
    repeat (8) step();
    total++;
    if (bus.note !== 4'd0 || bus.state !== 2'd0) begin
      bad++;
      $display("FAIL go_idle: note=%0d state=%0d required note=0 state=0", bus.note, bus.state);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.key = 9'd0;
    repeat (3) step();
    total++;
    if (bus.note !== 4'd0 || bus.note_on !== 1'b0 || bus.note_chg !== 1'b0 || bus.state !== 2'd0) begin
      bad++;
      $display("FAIL reset: note=%0d on=%b chg=%b state=%0d required 0/0/0/0",
               bus.note, bus.note_on, bus.note_chg, bus.state);
    end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single_key();
    int early;
    bus.key = 9'h001;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.note !== 4'd0 || bus.note_chg !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL single_early: %0d early changes required 0", early);
    end
    step();
    total++;
    if (bus.note !== 4'd1 || bus.note_on !== 1'b1 || bus.note_chg !== 1'b1) begin
      bad++;
      $display("FAIL single_commit: note=%0d on=%b chg=%b required 1/1/1",
               bus.note, bus.note_on, bus.note_chg);
    end
    step();
    total++;
    if (bus.note !== 4'd1 || bus.note_chg !== 1'b0 || bus.state !== 2'd2) begin
      bad++;
      $display("FAIL single_after: note=%0d chg=%b state=%0d required 1/0/2",
               bus.note, bus.note_chg, bus.state);
    end
    go_idle();
  endtask

  task automatic test_glitch();
    int seen;
    bus.key = 9'h010;
    repeat (3) step();
    bus.key = 9'h000;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.note !== 4'd0 || bus.note_chg !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL glitch: %0d cycles with note/chg active required 0", seen);
    end
  endtask

  task automatic test_priority();
    int early;
    int pulses;
    bus.key = 9'h022;
    repeat (7) step();
    total++;
    if (bus.note !== 4'd2 || bus.note_chg !== 1'b1) begin
      bad++;
      $display("FAIL prio_two: note=%0d chg=%b required 2/1", bus.note, bus.note_chg);
    end
    step();
    bus.key = 9'h020;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.note !== 4'd2 || bus.note_chg !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL prio_hold: %0d early changes required 0", early);
    end
    step();
    total++;
    if (bus.note !== 4'd6 || bus.note_chg !== 1'b1 || bus.note_on !== 1'b1) begin
      bad++;
      $display("FAIL prio_six: note=%0d chg=%b on=%b required 6/1/1",
               bus.note, bus.note_chg, bus.note_on);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.note_chg === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0 || bus.note !== 4'd6) begin
      bad++;
      $display("FAIL prio_single_pulse: extra pulses=%0d note=%0d required 0/6", pulses, bus.note);
    end
    go_idle();
  endtask

`ifndef SUSTAIN_EN
  task automatic test_release();
    int early;
    bus.key = 9'h100;
    repeat (7) step();
    total++;
    if (bus.note !== 4'd9 || bus.note_on !== 1'b1) begin
      bad++;
      $display("FAIL release_nine: note=%0d on=%b required 9/1", bus.note, bus.note_on);
    end
    repeat (2) step();
    bus.key = 9'h000;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.note !== 4'd9 || bus.note_on !== 1'b1 || bus.note_chg !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL release_hold: %0d early changes required 0", early);
    end
    step();
    total++;
    if (bus.note !== 4'd0 || bus.note_on !== 1'b0 || bus.note_chg !== 1'b1 || bus.state !== 2'd0) begin
      bad++;
      $display("FAIL release_zero: note=%0d on=%b chg=%b state=%0d required 0/0/1/0",
               bus.note, bus.note_on, bus.note_chg, bus.state);
    end
  endtask
`else
  task automatic test_sustain();
    int early;
    bus.key = 9'h004;
    repeat (9) step();
    bus.key = 9'h000;
    early = 0;
    for (int i = 0; i < 22; i++) begin
      step();
      if (bus.note !== 4'd3 || bus.note_chg !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL sustain_hold: %0d early changes required 0", early);
    end
    total++;
    if (bus.state !== 2'd3) begin
      bad++;
      $display("FAIL sustain_state: state=%0d required 3", bus.state);
    end
    step();
    total++;
    if (bus.note !== 4'd0 || bus.note_chg !== 1'b1 || bus.note_on !== 1'b0) begin
      bad++;
      $display("FAIL sustain_end: note=%0d chg=%b on=%b required 0/1/0",
               bus.note, bus.note_chg, bus.note_on);
    end
    go_idle();
    bus.key = 9'h004;
    repeat (9) step();
    bus.key = 9'h000;
    repeat (10) step();
    bus.key = 9'h040;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.note !== 4'd3 || bus.note_chg !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL sustain_replace_hold: %0d zero glitches or early changes required 0", early);
    end
    step();
    total++;
    if (bus.note !== 4'd7 || bus.note_chg !== 1'b1 || bus.state !== 2'd2) begin
      bad++;
      $display("FAIL sustain_replace: note=%0d chg=%b state=%0d required 7/1/2",
               bus.note, bus.note_chg, bus.state);
    end
    go_idle();
  endtask
`endif

  task automatic test_reset_mid();
    int early;
    bus.key = 9'h010;
    repeat (9) step();
    total++;
    if (bus.note !== 4'd5) begin
      bad++;
      $display("FAIL midrst_five: note=%0d required 5", bus.note);
    end
    bus.key = 9'h001;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.note !== 4'd0 || bus.note_chg !== 1'b0 || bus.note_on !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: note=%0d chg=%b on=%b required 0/0/0",
               bus.note, bus.note_chg, bus.note_on);
    end
    repeat (2) step();
    rst_n = 1'b1;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.note !== 4'd0 || bus.note_chg !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL midrst_early: %0d early changes required 0", early);
    end
    step();
    total++;
    if (bus.note !== 4'd1 || bus.note_chg !== 1'b1) begin
      bad++;
      $display("FAIL midrst_recommit: note=%0d chg=%b required 1/1", bus.note, bus.note_chg);
    end
    go_idle();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    bus.key = 9'd0;
    #1;
    test_reset();
    test_single_key();
    test_glitch();
    test_priority();
`ifndef SUSTAIN_EN
    test_release();
`else
    test_sustain();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
